// File: rtl/intr_handler_rr.sv
// Round-robin interrupt/acknowledge controller: grants one of N_CH request lines at a time,
// enables the shared counter while serving, and bounds each service with an extendable timeout.
module intr_handler_rr #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int TMO   = 16,
    parameter int SW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CH-1:0]   eql,
    input  logic [N_CH-1:0]   cont_eql,
    output logic [SW-1:0]     cc_mux,
    output logic [1:0]        uscite,
    output logic              enable_count,
    output logic [N_CH-1:0]   ackout,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SERVE,
        TIMEOUT,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO - 1);

    state_t           state, state_nxt;
    logic [SW-1:0]    g, g_nxt;
    logic [SW-1:0]    ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SW-1:0]    pick_idx;

    // Lowest rotational distance from ptr among the set request bits wins.
    always_comb begin
        int best_off;
        int off;
        best_off = N_CH;
        off      = 0;
        pick_idx = '0;
        for (int j = 0; j < N_CH; j++) begin
            off = (j + N_CH - int'(ptr)) % N_CH;
            if (eql[j] && (off < best_off)) begin
                best_off = off;
                pick_idx = SW'(j);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
            count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        cnt_nxt   = count;
        case (state)
            IDLE: begin
                if (|eql) begin
                    g_nxt     = pick_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                cnt_nxt   = '0;
                state_nxt = SERVE;
            end
            SERVE: begin
                // A dropped request beats an expiry on the same edge.
                if (!eql[g]) begin
                    state_nxt = RELEASE;
                end else if (count == LAST) begin
                    if (cont_eql[g]) begin
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = TIMEOUT;
                    end
                end else begin
                    cnt_nxt = count + CNT_W'(1);
                end
            end
            TIMEOUT: begin
                if (!eql[g]) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                ptr_nxt   = (int'(g) == N_CH - 1) ? '0 : g + SW'(1);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        ackout       = '0;
        uscite       = 2'b00;
        enable_count = 1'b0;
        case (state)
            GRANT: begin
                ackout[g] = 1'b1;
            end
            SERVE: begin
                uscite       = 2'b01;
                enable_count = 1'b1;
            end
            TIMEOUT: begin
                uscite = 2'b10;
            end
            RELEASE: begin
                uscite = 2'b11;
            end
            default: begin
            end
        endcase
    end

    assign busy   = (state != IDLE);
    assign cc_mux = g;

endmodule

// File: tb/tb_intr_handler_rr.sv
// Self-checking bench for intr_handler_rr: directed scenarios plus randomized requests,
// all compared each cycle against a behavioural model of the arbitration/service rules.
module tb_intr_handler_rr;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int TMO   = 4;
    localparam int SW    = 2;

    localparam int PH_IDLE    = 0;
    localparam int PH_GRANT   = 1;
    localparam int PH_SERVE   = 2;
    localparam int PH_TIMEOUT = 3;
    localparam int PH_RELEASE = 4;

    logic             clock;
    logic             reset;
    logic [N_CH-1:0]  eql;
    logic [N_CH-1:0]  cont_eql;
    logic [SW-1:0]    cc_mux;
    logic [1:0]       uscite;
    logic             enable_count;
    logic [N_CH-1:0]  ackout;
    logic [CNT_W-1:0] count;
    logic             busy;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_g;
    int m_ptr;
    int m_cnt;

    int serve_seen;
    int last_uscite;
    int ack_log[$];
    int rr_exp[5] = '{0, 1, 2, 3, 0};

    intr_handler_rr #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .TMO   (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .ackout       (ackout),
        .count        (count),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_g     = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Advance the reference model by one clock edge using the inputs held across that edge.
    task automatic model_step();
        int found;
        case (m_phase)
            PH_IDLE: begin
                found = 0;
                for (int off = 0; off < N_CH; off++) begin
                    if (!found && eql[(m_ptr + off) % N_CH]) begin
                        m_g   = (m_ptr + off) % N_CH;
                        found = 1;
                    end
                end
                if (found != 0) m_phase = PH_GRANT;
            end
            PH_GRANT: begin
                m_cnt   = 0;
                m_phase = PH_SERVE;
            end
            PH_SERVE: begin
                if (!eql[m_g])                             m_phase = PH_RELEASE;
                else if (m_cnt == TMO - 1 && cont_eql[m_g]) m_cnt   = 0;
                else if (m_cnt == TMO - 1)                 m_phase = PH_TIMEOUT;
                else                                       m_cnt   = m_cnt + 1;
            end
            PH_TIMEOUT: begin
                if (!eql[m_g]) m_phase = PH_RELEASE;
            end
            default: begin
                m_ptr   = (m_g + 1) % N_CH;
                m_phase = PH_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        int exp_us;
        exp_us = (m_phase == PH_SERVE) ? 1 : (m_phase == PH_TIMEOUT) ? 2 : (m_phase == PH_RELEASE) ? 3 : 0;
        checkOutput("uscite", 32'(uscite), 32'(exp_us));
        checkOutput("enable_count", 32'(enable_count), 32'(m_phase == PH_SERVE));
        checkOutput("ackout", 32'(ackout), (m_phase == PH_GRANT) ? (32'd1 << m_g) : 32'd0);
        checkOutput("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        checkOutput("cc_mux", 32'(cc_mux), 32'(m_g));
        checkOutput("count", 32'(count), 32'(m_cnt));
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] e, input logic [N_CH-1:0] c);
        @(negedge clock);
        check_all();
        last_uscite = int'(uscite);
        if (enable_count) serve_seen++;
        for (int i = 0; i < N_CH; i++) begin
            if (ackout[i]) ack_log.push_back(i);
        end
        eql      = e;
        cont_eql = c;
        @(posedge clock);
        model_step();
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_uscite"}, 32'(uscite), 32'd0);
        checkOutput({tag, "_enable"}, 32'(enable_count), 32'd0);
        checkOutput({tag, "_ackout"}, 32'(ackout), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cc_mux"}, 32'(cc_mux), 32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
    endtask

    // Assert reset between edges, check the asynchronous effect, then release on a falling edge.
    task automatic doReset();
        @(negedge clock);
        check_all();
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        eql      = '0;
        cont_eql = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [N_CH-1:0] rnd_eql;
        clock    = 1'b0;
        reset    = 1'b0;
        eql      = '0;
        cont_eql = '0;
        model_reset();
        #3 check_reset_values("init_reset");
        @(negedge clock);
        reset = 1'b1;

        // Round-robin with all lines requesting: each granted line drops after three serve cycles.
        ack_log.delete();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'hF, 4'h0);
            applyStimulus(4'hF, 4'h0);
            applyStimulus(4'hF, 4'h0);
            applyStimulus(4'hF, 4'h0);
            applyStimulus(4'hF & ~(4'h1 << m_g), 4'h0);
            applyStimulus(4'hF, 4'h0);
        end
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);
        checkOutput("rr_grants", 32'(ack_log.size()), 32'd5);
        for (int i = 0; i < ack_log.size() && i < 5; i++) begin
            checkOutput("rr_order", 32'(ack_log[i]), 32'(rr_exp[i]));
        end

        // Timeout without extension on channel 2.
        serve_seen = 0;
        for (int i = 0; i < 8; i++) applyStimulus(4'b0100, 4'h0);
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);
        checkOutput("rel_after_tmo", 32'(last_uscite), 32'd3);
        applyStimulus(4'h0, 4'h0);
        checkOutput("tmo_serve_len", 32'(serve_seen), 32'(TMO));

        // One extension on channel 1, then a plain timeout.
        serve_seen = 0;
        for (int i = 0; i < 6; i++) applyStimulus(4'b0010, 4'b0010);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 4'h0);
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);
        checkOutput("ext_serve_len", 32'(serve_seen), 32'(2 * TMO));

        // Request drops on the same edge the counter expires: release wins.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);
        checkOutput("simul_release", 32'(last_uscite), 32'd3);

        // Channel 3 served while channel 0 asserts: channel 0 waits, then wins after the wrap.
        ack_log.delete();
        applyStimulus(4'b1000, 4'h0);
        applyStimulus(4'b1000, 4'h0);
        applyStimulus(4'b1001, 4'h0);
        applyStimulus(4'b1001, 4'h0);
        applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'b0001, 4'h0);
        checkOutput("wrap_grants", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            checkOutput("wrap_first", 32'(ack_log[0]), 32'd3);
            checkOutput("wrap_second", 32'(ack_log[1]), 32'd0);
        end

        // Reset in the middle of serving channel 0, then a fresh grant from ptr 0.
        applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'b0001, 4'h0);
        doReset();
        applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'b0001, 4'h0);
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0);

        // Randomized requests with persistence and occasional mid-service resets.
        rnd_eql = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N_CH; b++) begin
                if ($urandom_range(0, 5) == 0) rnd_eql[b] = ~rnd_eql[b];
            end
            if ($urandom_range(0, 249) == 0) begin
                doReset();
            end else begin
                applyStimulus(rnd_eql, 4'($urandom) & 4'($urandom));
            end
        end
        applyStimulus(4'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
